bias_relu_stage: RTL

- Post-processing stage directly downstream of the vector-matrix product block in a dense layer.
- Captures the NUM_COL_MAT-element product vector when the product block's done rises, then adds a per-neuron bias, saturates and optionally applies ReLU.
- Processes one element per clock and publishes a stable activation vector plus argmax index for the next layer or classifier readout.

---
 rtl/nn_fixed_pkg.sv | 30 +++
 rtl/act_unit.sv | 18 +
 rtl/bias_relu_stage.sv | 116 +++++++++++
 3 files changed

// File: rtl/nn_fixed_pkg.sv
// rtl/nn_fixed_pkg.sv - fixed-point helpers shared by the dense-layer post-processing stages
package nn_fixed_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sum is formed one bit wider; disagreeing top bits mean the word overflowed.
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1]) begin
      return s[DATA_W] ? SAT_MIN : SAT_MAX;
    end
    return s[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/act_unit.sv
// rtl/act_unit.sv - saturating bias add followed by optional ReLU, one element per use
module act_unit
  import nn_fixed_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              relu_en,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W-1:0] sat;

  always_comb begin
    sat = sat_add(a, b);
    y   = (relu_en && sat[DATA_W-1]) ? '0 : sat;
  end

endmodule

// File: rtl/bias_relu_stage.sv
// rtl/bias_relu_stage.sv - captures a product vector, applies bias/saturate/ReLU serially, publishes result and argmax
module bias_relu_stage
  import nn_fixed_pkg::*;
#(
  parameter int FRACTION_WIDTH = 15,
  parameter int BIT_WIDTH      = 32,
  parameter int NUM_COL_MAT    = 5,
  localparam int IDX_W         = idx_width(NUM_COL_MAT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] vec_in  [NUM_COL_MAT],
  input  logic [BIT_WIDTH-1:0] bias    [NUM_COL_MAT],
  input  logic                 relu_en,
  output logic [BIT_WIDTH-1:0] act_out [NUM_COL_MAT],
  output logic [IDX_W-1:0]     max_idx,
  output logic                 busy,
  output logic                 done
);

  if (BIT_WIDTH != DATA_W || FRACTION_WIDTH >= BIT_WIDTH) begin : g_cfg_err
    $error("bias_relu_stage: word format does not match nn_fixed_pkg");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COL_MAT - 1);

  state_t               state;
  logic                 in_valid_q;
  logic                 start;
  logic [IDX_W-1:0]     idx;
  logic [BIT_WIDTH-1:0] vec_reg  [NUM_COL_MAT];
  logic [BIT_WIDTH-1:0] bias_reg [NUM_COL_MAT];
  logic                 relu_en_reg;
  logic [BIT_WIDTH-1:0] work_buf [NUM_COL_MAT];
  logic [BIT_WIDTH-1:0] max_val;
  logic [IDX_W-1:0]     max_idx_run;
  logic [BIT_WIDTH-1:0] act_y;
  logic                 take_max;

  assign start = in_valid & ~in_valid_q;

  act_unit u_act (
    .a       (vec_reg[idx]),
    .b       (bias_reg[idx]),
    .relu_en (relu_en_reg),
    .y       (act_y)
  );

  // Element 0 always seeds the running max so all-negative vectors still get a valid index.
  assign take_max = (idx == '0) || ($signed(act_y) > $signed(max_val));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_valid_q  <= 1'b0;
      idx         <= '0;
      relu_en_reg <= 1'b0;
      max_val     <= '0;
      max_idx_run <= '0;
      max_idx     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int i = 0; i < NUM_COL_MAT; i++) begin
        vec_reg[i]  <= '0;
        bias_reg[i] <= '0;
        work_buf[i] <= '0;
        act_out[i]  <= '0;
      end
    end else begin
      in_valid_q <= in_valid;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            for (int i = 0; i < NUM_COL_MAT; i++) begin
              vec_reg[i]  <= vec_in[i];
              bias_reg[i] <= bias[i];
            end
            relu_en_reg <= relu_en;
            idx         <= '0;
            max_val     <= '0;
            max_idx_run <= '0;
            state       <= RUN;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        RUN: begin
          work_buf[idx] <= act_y;
          if (take_max) begin
            max_val     <= act_y;
            max_idx_run <= idx;
          end
          if (idx == LAST_IDX) begin
            // The last element bypasses work_buf so the published vector is complete on this edge.
            for (int i = 0; i < NUM_COL_MAT; i++) begin
              act_out[i] <= (i == NUM_COL_MAT - 1) ? act_y : work_buf[i];
            end
            max_idx <= take_max ? idx : max_idx_run;
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
